// File: rtl/branch_sequencer.sv
// branch_sequencer: PC sequencer with a START/HALT run FSM, conditional
// branches, call/return through a small hardware return stack, and a
// one-cycle TAKEN/FLUSH pulse after every redirect. The PC is computed and
// loaded in the same cycle its inputs are sampled.
module branch_sequencer #(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int OFFW = 8,
  parameter int RSD  = 4,
  parameter int INC  = 2
) (
  input  logic                       CLOCK,
  input  logic                       CLEAR,
  input  logic                       START,
  input  logic                       HALT,
  input  logic                       STALL,
  input  logic [1:0]                 BRANCH,
  input  logic [DW-1:0]              OP_A,
  input  logic [DW-1:0]              OP_B,
  input  logic [OFFW-1:0]            OFFSET,
  input  logic                       JAL,
  input  logic                       RET,
  output logic [AW-1:0]              PC,
  output logic [AW-1:0]              NEXT_PC,
  output logic                       TAKEN,
  output logic                       FLUSH,
  output logic                       RUNNING,
  output logic                       RS_OVF,
  output logic                       RS_UNF,
  output logic [$clog2(RSD+1)-1:0]   RS_COUNT
);

  localparam int CW = $clog2(RSD + 1);
  localparam int IW = (RSD > 1) ? $clog2(RSD) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_d;
  logic [AW-1:0]       r_pc;
  logic [AW-1:0]       w_pc_d;
  logic                r_taken;
  logic [CW-1:0]       r_count;
  logic                r_ovf;
  logic                r_unf;
  logic [AW-1:0]       r_stack [RSD];

  logic signed [DW-1:0]   w_a;
  logic signed [DW-1:0]   w_b;
  logic signed [OFFW-1:0] w_off;
  logic signed [AW-1:0]   w_off_ext;
  logic [AW-1:0]          w_target;
  logic [AW-1:0]          w_seq_pc;
  logic                   w_br_take;
  logic [IW-1:0]          w_top_idx;
  logic [IW-1:0]          w_push_idx;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_set_ovf;
  logic                   w_set_unf;
  logic                   w_redirect;
  logic                   w_stack_full;

  // Operand views, branch target (word offset scaled to bytes) and sequential PC
  always_comb begin
    w_a          = OP_A;
    w_b          = OP_B;
    w_off        = OFFSET;
    w_off_ext    = AW'(w_off);
    w_target     = r_pc + AW'(w_off_ext <<< 1);
    w_seq_pc     = r_pc + AW'(INC);
    w_top_idx    = IW'(r_count - CW'(1));
    w_push_idx   = IW'(r_count);
    w_stack_full = (r_count == CW'(RSD));
    case (BRANCH)
      2'b01:   w_br_take = (w_a == w_b);
      2'b10:   w_br_take = (w_a <  w_b);
      2'b11:   w_br_take = (w_a >  w_b);
      default: w_br_take = 1'b0;
    endcase
  end

  // Next-state and next-PC decision: HALT > STALL > RET > JAL > BRANCH > sequential
  always_comb begin
    w_state_d  = r_state;
    w_pc_d     = r_pc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_unf  = 1'b0;
    w_redirect = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_state_d = S_RUN;
      end
      S_HALTED: begin
        if (START) w_state_d = S_RUN;
      end
      S_RUN: begin
        if (HALT) begin
          w_state_d = S_HALTED;
        end else if (STALL) begin
          w_pc_d = r_pc;
        end else if (RET) begin
          // A simultaneous JAL is dropped: return wins and nothing is pushed
          if (r_count != '0) begin
            w_pop      = 1'b1;
            w_pc_d     = r_stack[w_top_idx];
            w_redirect = 1'b1;
          end else begin
            w_set_unf = 1'b1;
            w_pc_d    = w_seq_pc;
          end
        end else if (JAL) begin
          // The jump happens even when the return address cannot be saved
          w_pc_d     = w_target;
          w_redirect = 1'b1;
          if (w_stack_full) w_set_ovf = 1'b1;
          else              w_push    = 1'b1;
        end else if (w_br_take) begin
          w_pc_d     = w_target;
          w_redirect = 1'b1;
        end else begin
          w_pc_d = w_seq_pc;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, PC, redirect pulse, stack pointer and sticky flags
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_taken <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_taken <= w_redirect;
      if (w_push)     r_count <= r_count + CW'(1);
      else if (w_pop) r_count <= r_count - CW'(1);
      r_ovf   <= r_ovf | w_set_ovf;
      r_unf   <= r_unf | w_set_unf;
    end
  end

  // Return-address storage; contents are only meaningful below r_count
  always_ff @(posedge CLOCK) begin
    if (w_push && !CLEAR) r_stack[w_push_idx] <= w_seq_pc;
  end

  assign PC       = r_pc;
  assign NEXT_PC  = CLEAR ? '0 : w_pc_d;
  assign TAKEN    = r_taken;
  assign FLUSH    = r_taken;
  assign RUNNING  = (r_state == S_RUN);
  assign RS_OVF   = r_ovf;
  assign RS_UNF   = r_unf;
  assign RS_COUNT = r_count;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: each vector pushes its expected
// post-edge state into a scoreboard queue; a monitor pops after each edge.
module tb_branch_sequencer;

  logic        CLOCK;
  logic        CLEAR;
  logic        START;
  logic        HALT;
  logic        STALL;
  logic [1:0]  BRANCH;
  logic [15:0] OP_A;
  logic [15:0] OP_B;
  logic [7:0]  OFFSET;
  logic        JAL;
  logic        RET;
  logic [15:0] PC;
  logic [15:0] NEXT_PC;
  logic        TAKEN;
  logic        FLUSH;
  logic        RUNNING;
  logic        RS_OVF;
  logic        RS_UNF;
  logic [2:0]  RS_COUNT;

  branch_sequencer #(.AW(16), .DW(16), .OFFW(8), .RSD(4), .INC(2)) dut (
    .CLOCK(CLOCK), .CLEAR(CLEAR), .START(START), .HALT(HALT), .STALL(STALL),
    .BRANCH(BRANCH), .OP_A(OP_A), .OP_B(OP_B), .OFFSET(OFFSET),
    .JAL(JAL), .RET(RET), .PC(PC), .NEXT_PC(NEXT_PC), .TAKEN(TAKEN),
    .FLUSH(FLUSH), .RUNNING(RUNNING), .RS_OVF(RS_OVF), .RS_UNF(RS_UNF),
    .RS_COUNT(RS_COUNT)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic        taken;
    logic        run;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t  q_exp [$];
  string q_tag [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  logic [2:0] e_cnt = 3'd0;
  logic       e_ovf = 1'b0;
  logic       e_unf = 1'b0;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d, required 0", q_exp.size());
    $fatal(1, "timeout");
  end

  // Monitor: compare registered outputs just after every active edge
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge CLOCK);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        n_tests++;
        if (PC !== e.pc || TAKEN !== e.taken || FLUSH !== e.taken || RUNNING !== e.run ||
            RS_COUNT !== e.cnt || RS_OVF !== e.ovf || RS_UNF !== e.unf) begin
          n_fail++;
          $display("FAIL %s: got pc=%h taken=%b flush=%b run=%b cnt=%0d ovf=%b unf=%b, expected pc=%h taken=%b run=%b cnt=%0d ovf=%b unf=%b",
                   t, PC, TAKEN, FLUSH, RUNNING, RS_COUNT, RS_OVF, RS_UNF,
                   e.pc, e.taken, e.run, e.cnt, e.ovf, e.unf);
        end
      end
    end
  end

  // One directed vector: drive inputs, queue expected post-edge state,
  // check the combinational NEXT_PC, then advance to the next falling edge
  task automatic v(input logic clr, input logic st, input logic hl, input logic sl,
                   input logic jl, input logic rt, input logic [1:0] br,
                   input logic [15:0] a, input logic [15:0] b, input logic [7:0] off,
                   input logic [15:0] epc, input logic etk, input logic erun,
                   input string tag);
    exp_t e;
    CLEAR = clr; START = st; HALT = hl; STALL = sl; JAL = jl; RET = rt;
    BRANCH = br; OP_A = a; OP_B = b; OFFSET = off;
    e.pc = epc; e.taken = etk; e.run = erun; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
    q_exp.push_back(e);
    q_tag.push_back(tag);
    #1;
    n_tests++;
    if (NEXT_PC !== epc) begin
      n_fail++;
      $display("FAIL %s_next_pc: got %h, expected %h", tag, NEXT_PC, epc);
    end
    @(negedge CLOCK);
  endtask

  initial begin
    logic [15:0] p;
    CLEAR = 1'b1; START = 1'b0; HALT = 1'b0; STALL = 1'b0; JAL = 1'b0; RET = 1'b0;
    BRANCH = 2'b00; OP_A = 16'd0; OP_B = 16'd0; OFFSET = 8'd0;
    @(negedge CLOCK);

    //  clr st hl sl jl rt br     a         b         off     exp_pc    tk run
    v(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b0,"reset");
    v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b1,"start");
    for (int i = 1; i <= 8; i++) begin
      p = 16'(2 * i);
      v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, p,1'b0,1'b1,"seq");
    end
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'd5,16'd5,8'hFE, 16'h000C,1'b1,1'b1,"beq_taken");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h000E,1'b0,1'b1,"after_beq");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0010,1'b0,1'b1,"seq_to_10");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'd6,16'd5,8'hFE, 16'h0012,1'b0,1'b1,"beq_not_taken");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,16'hFFFF,16'd1,8'h04, 16'h001A,1'b1,1'b1,"blt_signed");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,16'hFFFF,16'd1,8'h04, 16'h001C,1'b0,1'b1,"bgt_signed_nt");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,16'd1,16'hFFFF,8'h04, 16'h0024,1'b1,1'b1,"bgt_signed_t");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'd0,16'd0,8'hFE, 16'h0020,1'b1,1'b1,"to_0x20");

    // Five calls: four pushes then an overflowing call that still jumps
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) e_cnt = 3'(i);
      else       e_ovf = 1'b1;
      p = 16'h0020 + 16'(i * 32);
      v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,16'd0,16'd0,8'h10, p,1'b1,1'b1,"jal");
    end
    // Four returns in LIFO order, then an underflowing return
    for (int i = 0; i < 4; i++) begin
      e_cnt = 3'(3 - i);
      p = 16'h0082 - 16'(i * 32);
      v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,16'd0,16'd0,8'h00, p,1'b1,1'b1,"ret_pop");
    end
    e_unf = 1'b1;
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,16'd0,16'd0,8'h00, 16'h0024,1'b0,1'b1,"ret_underflow");

    e_cnt = 3'd1;
    v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,16'd0,16'd0,8'h10, 16'h0044,1'b1,1'b1,"jal_again");
    e_cnt = 3'd0;
    v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,16'd0,16'd0,8'h10, 16'h0026,1'b1,1'b1,"jal_ret_together");
    v(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,16'd0,16'd0,8'h10, 16'h0026,1'b0,1'b1,"stall_jal");
    v(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b01,16'd0,16'd0,8'h10, 16'h0026,1'b0,1'b0,"halt_priority");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'd0,16'd0,8'h10, 16'h0026,1'b0,1'b0,"halted_hold");

    e_cnt = 3'd0; e_ovf = 1'b0; e_unf = 1'b0;
    v(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b0,"clear_in_halted");
    v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b1,"restart");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0002,1'b0,1'b1,"seq_to_2");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'd0,16'd0,8'h80, 16'hFF02,1'b1,1'b1,"neg_offset_wrap");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,16'd0,16'd0,8'h7E, 16'hFFFE,1'b1,1'b1,"to_fffe");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b1,"seq_wrap");

    e_cnt = 3'd1;
    v(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,16'd0,16'd0,8'h10, 16'h0020,1'b1,1'b1,"jal_pre_clear");
    e_cnt = 3'd0;
    v(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,16'd0,16'd0,8'h10, 16'h0000,1'b0,1'b0,"clear_mid_call");
    v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b1,"start2");
    v(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b0,"halt_start_together");
    v(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0000,1'b0,1'b1,"halted_to_run");
    v(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,16'd0,16'd0,8'h00, 16'h0002,1'b0,1'b1,"seq_after_restart");

    repeat (2) @(negedge CLOCK);
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
